logic_key_alu: RTL and testbench

- Parametrised successor to the board's key/LED logic-gate lab block.
- Debounces two active-low push keys and latches two WIDTH-bit operands from the switches in sequence.
- Cycles through a set of bitwise operations and drives a registered result toward the LEDs.
- Sits between the board top (key, sw, led) and the LED/hex display logic.

---
 rtl/logic_key_alu.sv | 193 +++++++++++++++++++
 tb/tb_logic_key_alu.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_key_alu.sv
// -----------------------------------------------------------------------------
// logic_key_alu
//
// Key/switch driven bitwise ALU for the board's LED lab. Two active-low push
// keys (LOAD, MODE) are synchronised and debounced into one-cycle press
// strobes. Successive LOAD presses latch operand A and then operand B from
// the switches. MODE presses step through the operation codes. The result is
// registered every cycle from the current operands and mode.
//
// Optional build macro: LOGIC_KEY_ALU_ARITH_EN
//   Defined   : adds ADD (code 6) and SUB (code 7); the mode wraps 7 -> 0.
//   Undefined : bitwise codes 0..5 only; the mode wraps 5 -> 0, and codes
//               6/7 yield a zero result.
// -----------------------------------------------------------------------------
module logic_key_alu #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       key_n,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [2:0]       mode,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [1:0]       state
);

    // Counter just wide enough to reach DEBOUNCE_CYCLES-1.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef LOGIC_KEY_ALU_ARITH_EN
    localparam logic [2:0] LAST_MODE = 3'd7;
`else
    localparam logic [2:0] LAST_MODE = 3'd5;
`endif

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        SHOW   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ADD  = 3'd6,
        OP_SUB  = 3'd7
    } op_t;

    // Press strobes: bit 0 = LOAD, bit 1 = MODE.
    logic [1:0] press;

    // -------------------------------------------------------------------------
    // Per-key conditioning: 2-FF synchroniser, debounce counter, press strobe.
    // Debounced level uses the raw key polarity (1 = released).
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < 2; k++) begin : g_key
        logic             sync_1;
        logic             sync_2;
        logic             level;
        logic             pulse;
        logic [CNT_W-1:0] cnt;

        // Synchronise, count consecutive disagreeing samples, flip on the last.
        // NOTE: sequential state is assigned with <= so every flop samples the
        // pre-edge value of its neighbours, giving a true two-stage shift.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_1 <= 1'b1;
                sync_2 <= 1'b1;
                level  <= 1'b1;
                cnt    <= '0;
                pulse  <= 1'b0;
            end else begin
                sync_1 <= key_n[k];
                sync_2 <= sync_1;
                pulse  <= 1'b0;
                if (sync_2 == level) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    level <= sync_2;
                    cnt   <= '0;
                    // Strobe only on released -> pressed (new level 0).
                    pulse <= ~sync_2;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        assign press[k] = pulse;
    end

    logic load_press;
    logic mode_press;
    assign load_press = press[0];
    assign mode_press = press[1];

    // -------------------------------------------------------------------------
    // Operand / mode FSM.
    // -------------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [2:0]       mode_d;

    // Next-state logic: LOAD walks A -> B -> show; MODE steps the op code.
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode;

        if (load_press) begin
            case (state_q)
                WAIT_A: begin
                    a_d     = data_in;
                    state_d = WAIT_B;
                end
                WAIT_B: begin
                    b_d     = data_in;
                    state_d = SHOW;
                end
                SHOW: begin
                    // New A restarts the pair; B is kept but not yet valid.
                    a_d     = data_in;
                    state_d = WAIT_B;
                end
                default: state_d = WAIT_A;
            endcase
        end

        if (mode_press) begin
            mode_d = (mode == LAST_MODE) ? 3'd0 : mode + 3'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Operation datapath.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] op_result;

    // Combinational result for the current operands and mode.
    always_comb begin
        op_result = '0;
        case (op_t'(mode))
            OP_AND:  op_result = a_q & b_q;
            OP_OR:   op_result = a_q | b_q;
            OP_XOR:  op_result = a_q ^ b_q;
            OP_NAND: op_result = ~(a_q & b_q);
            OP_NOR:  op_result = ~(a_q | b_q);
            OP_XNOR: op_result = ~(a_q ^ b_q);
`ifdef LOGIC_KEY_ALU_ARITH_EN
            OP_ADD:  op_result = a_q + b_q;
            OP_SUB:  op_result = a_q - b_q;
`endif
            default: op_result = '0;
        endcase
    end

    // State, operands, mode and result registers; result_valid tracks state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= WAIT_A;
            a_q          <= '0;
            b_q          <= '0;
            mode         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            mode         <= mode_d;
            result       <= op_result;
            result_valid <= (state_d == SHOW);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_logic_key_alu.sv
// -----------------------------------------------------------------------------
// tb_logic_key_alu
//
// Directed bench for logic_key_alu with WIDTH = 4, DEBOUNCE_CYCLES = 4.
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
// A key held low is accepted on the 6th edge (2 sync + 4 debounce) and acted
// on by the FSM at the 7th edge; result follows one edge after that.
// -----------------------------------------------------------------------------
module tb_logic_key_alu;

    logic       clk;
    logic       reset_n;
    logic [1:0] key_n;
    logic [3:0] data_in;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [2:0] mode;
    logic [3:0] result;
    logic       result_valid;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    logic_key_alu #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_n        (key_n),
        .data_in      (data_in),
        .a_q          (a_q),
        .b_q          (b_q),
        .mode         (mode),
        .result       (result),
        .result_valid (result_valid),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the given keys (bit set = pressed) long enough to be accepted,
    // then release them long enough to return to the released level.
    task automatic press(input logic [1:0] keys);
        key_n = ~keys;
        repeat (8) tick();
        key_n = 2'b11;
        repeat (8) tick();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        key_n   = 2'b11;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic load_pair(input logic [3:0] a, input logic [3:0] b);
        data_in = a;
        press(2'b01);
        data_in = b;
        press(2'b01);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        key_n   = 2'b11;
        data_in = 4'h0;
        repeat (3) tick();
        checks++;
        if ({a_q, b_q, mode, result, result_valid, state} !== 18'h0) begin
            errors++;
            $display("FAIL reset_held: got a=%h b=%h mode=%0d res=%h valid=%b state=%0d, expected all 0",
                     a_q, b_q, mode, result, result_valid, state);
        end
        reset_n = 1'b1;
        repeat (10) tick();
        checks++;
        if ({a_q, b_q, mode, result, result_valid, state} !== 18'h0) begin
            errors++;
            $display("FAIL reset_idle: got a=%h b=%h mode=%0d res=%h valid=%b state=%0d, expected all 0",
                     a_q, b_q, mode, result, result_valid, state);
        end
    endtask

    task automatic test_bounce();
        apply_reset();
        data_in = 4'h3;
        key_n = 2'b11; repeat (2) tick();
        key_n = 2'b10; repeat (2) tick();
        key_n = 2'b11; repeat (2) tick();
        // Stable low begins here.
        key_n = 2'b10;
        repeat (6) tick();
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL bounce_early: state got %0d expected 0", state);
        end
        tick();
        checks++;
        if (state !== 2'd1 || a_q !== 4'h3) begin
            errors++;
            $display("FAIL bounce_accept: state=%0d a=%h expected state=1 a=3", state, a_q);
        end
        // Remainder of a 10-cycle hold, then release: no further strobe.
        repeat (3) tick();
        key_n = 2'b11;
        repeat (10) tick();
        checks++;
        if (state !== 2'd1 || b_q !== 4'h0) begin
            errors++;
            $display("FAIL bounce_single: state=%0d b=%h expected state=1 b=0", state, b_q);
        end
    endtask

    task automatic test_operands();
        apply_reset();
        data_in = 4'hC;
        press(2'b01);
        checks++;
        if (state !== 2'd1 || a_q !== 4'hC || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_a: state=%0d a=%h valid=%b expected 1 C 0", state, a_q, result_valid);
        end
        data_in = 4'hA;
        press(2'b01);
        checks++;
        if (a_q !== 4'hC || b_q !== 4'hA) begin
            errors++;
            $display("FAIL load_b_ops: a=%h b=%h expected C A", a_q, b_q);
        end
        checks++;
        if (state !== 2'd2 || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL load_b_show: state=%0d valid=%b expected 2 1", state, result_valid);
        end
        checks++;
        if (result !== 4'h8) begin
            errors++;
            $display("FAIL and_result: got %h expected 8", result);
        end
    endtask

    task automatic test_modes();
        // C op A for OR, XOR, NAND, NOR, XNOR, then AND after the wrap.
        logic [3:0] exp_res [6] = '{4'hE, 4'h6, 4'h7, 4'h1, 4'h9, 4'h8};
        logic [2:0] exp_mode [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        for (int i = 0; i < 6; i++) begin
            press(2'b10);
            checks++;
            if (mode !== exp_mode[i] || result !== exp_res[i]) begin
                errors++;
                $display("FAIL mode_step%0d: mode=%0d res=%h expected mode=%0d res=%h",
                         i, mode, result, exp_mode[i], exp_res[i]);
            end
        end
        checks++;
        if (state !== 2'd2 || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL mode_keeps_show: state=%0d valid=%b expected 2 1", state, result_valid);
        end
    endtask

    task automatic test_simultaneous();
        data_in = 4'h5;
        key_n   = 2'b00;
        repeat (7) tick();
        checks++;
        if (a_q !== 4'h5 || mode !== 3'd1 || state !== 2'd1 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL both_keys: a=%h mode=%0d state=%0d valid=%b expected 5 1 1 0",
                     a_q, mode, state, result_valid);
        end
        checks++;
        if (result !== 4'h8) begin
            errors++;
            $display("FAIL both_keys_lag: result got %h expected 8 (previous)", result);
        end
        tick();
        checks++;
        if (result !== 4'hF) begin
            errors++;
            $display("FAIL both_keys_result: got %h expected F", result);
        end
        key_n = 2'b11;
        repeat (8) tick();
    endtask

    task automatic test_async_reset();
        data_in = 4'hA;
        press(2'b01);
        checks++;
        if (state !== 2'd2 || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_show: state=%0d valid=%b expected 2 1", state, result_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({a_q, b_q, mode, result, result_valid, state} !== 18'h0) begin
            errors++;
            $display("FAIL async_reset: got a=%h b=%h mode=%0d res=%h valid=%b state=%0d, expected all 0",
                     a_q, b_q, mode, result, result_valid, state);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        apply_reset();
        load_pair(4'hC, 4'hA);
        repeat (5) press(2'b10);
        checks++;
        if (mode !== 3'd5 || result !== 4'h9) begin
            errors++;
            $display("FAIL mode5: mode=%0d res=%h expected 5 9", mode, result);
        end
        press(2'b10);
`ifdef LOGIC_KEY_ALU_ARITH_EN
        checks++;
        if (mode !== 3'd6 || result !== 4'h6) begin
            errors++;
            $display("FAIL add_mode: mode=%0d res=%h expected 6 6", mode, result);
        end
        press(2'b10);
        checks++;
        if (mode !== 3'd7 || result !== 4'h2) begin
            errors++;
            $display("FAIL sub_mode: mode=%0d res=%h expected 7 2", mode, result);
        end
        press(2'b10);
`endif
        checks++;
        if (mode !== 3'd0 || result !== 4'h8) begin
            errors++;
            $display("FAIL mode_wrap: mode=%0d res=%h expected 0 8", mode, result);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_operands();
        test_modes();
        test_simultaneous();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
